serial_rx_fifo: RTL and testbench

Parametrised 2-wire serial receiver for the input operation. An external microcontroller drives serial_clk and serial_data. The block samples one bit per synchronised serial_clk rising edge, assembles DATA_W-bit words and buffers them in a first-word-fall-through FIFO with a valid/ready read port. It adds selectable bit order, a partial-frame timeout and overrun detection.

---
 rtl/serial_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_serial_rx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 2-wire serial receiver with word assembly and a
// first-word-fall-through FIFO read port.
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              receiver enable (FIFO/read port keep running when low)
//   serial_clk/data     asynchronous bit clock and data from the master
//   rd_valid/ready/data FWFT read port; rd_data is 0 while rd_valid=0
//   level               FIFO occupancy 0..FIFO_DEPTH
//   overrun, clr_overrun  sticky word-dropped flag and its clear
//   frame_abort         1-cycle pulse when a partial word times out
module serial_rx_fifo #(
  parameter int DATA_W      = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          serial_clk,
  input  logic                          serial_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          frame_abort
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(DATA_W);
  localparam int TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_prev;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_W-1:0]      r_shift;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_frame_abort;
  logic                   r_overrun;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;
  logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];

  logic                   w_rise;
  logic                   w_bit;
  logic                   w_timeout;
  logic [CW-1:0]          w_cnt_eff;
  logic [DATA_W-1:0]      w_shift_eff;
  logic [DATA_W-1:0]      w_merged;
  logic                   w_push;
  logic [CW-1:0]          w_cnt_nxt;
  logic [DATA_W-1:0]      w_shift_nxt;
  logic [TW-1:0]          w_to_nxt;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr_en;

  // Edge detect runs regardless of enable so re-enabling with serial_clk
  // already high cannot look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], serial_clk};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], serial_data};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_bit  = r_sdat_sync[SYNC_STAGES-1];

  // A timeout discards the partial word first, so a coincident rise is
  // assembled as bit 0 of a fresh word.
  always_comb begin
    w_timeout   = (TIMEOUT_CYC > 0) && enable && (r_bit_cnt != '0) &&
                  (r_to_cnt == TW'(TO_LAST));
    w_cnt_eff   = w_timeout ? '0 : r_bit_cnt;
    w_shift_eff = w_timeout ? '0 : r_shift;
    w_merged    = (MSB_FIRST != 0) ? {w_shift_eff[DATA_W-2:0], w_bit}
                                   : {w_bit, w_shift_eff[DATA_W-1:1]};
    w_push      = 1'b0;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_to_nxt    = r_to_cnt;
    if (!enable) begin
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_to_nxt    = '0;
    end else if (w_rise) begin
      w_to_nxt = '0;
      if (w_cnt_eff == CW'(DATA_W - 1)) begin
        w_push      = 1'b1;
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
      end else begin
        w_cnt_nxt   = w_cnt_eff + 1'b1;
        w_shift_nxt = w_merged;
      end
    end else if (w_timeout) begin
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_to_nxt    = '0;
    end else if ((r_bit_cnt != '0) && (TIMEOUT_CYC > 0)) begin
      w_to_nxt = r_to_cnt + 1'b1;
    end else begin
      w_to_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_to_cnt      <= '0;
      r_frame_abort <= 1'b0;
    end else begin
      r_bit_cnt     <= w_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_to_cnt      <= w_to_nxt;
      r_frame_abort <= w_timeout;
    end
  end

  assign w_full  = (r_level == (AW + 1)'(FIFO_DEPTH));
  assign w_pop   = rd_valid & rd_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push & w_full & ~w_pop) r_overrun <= 1'b1;
      else if (clr_overrun)          r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_merged;
  end

  assign rd_valid    = (r_level != '0);
  assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign level       = r_level;
  assign overrun     = r_overrun;
  assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Bench for serial_rx_fifo: a default (MSB-first) instance plus an LSB-first
// instance sharing the serial pins. Expected words come from a queue model.
module tb_serial_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       serial_clk = 1'b0;
  logic       serial_data = 1'b0;
  logic       rd_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       rd_ready_l = 1'b0;
  logic       clr_l = 1'b0;

  logic       rd_valid, overrun, frame_abort;
  logic [9:0] rd_data;
  logic [2:0] level;
  logic       lsb_valid, lsb_ovr, lsb_abort;
  logic [9:0] lsb_data;
  logic [2:0] lsb_level;

  serial_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .serial_clk(serial_clk), .serial_data(serial_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .overrun(overrun), .clr_overrun(clr_overrun),
    .frame_abort(frame_abort)
  );

  serial_rx_fifo #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .serial_clk(serial_clk), .serial_data(serial_data),
    .rd_valid(lsb_valid), .rd_ready(rd_ready_l), .rd_data(lsb_data),
    .level(lsb_level), .overrun(lsb_ovr), .clr_overrun(clr_l),
    .frame_abort(lsb_abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_abort = 0;
  logic [9:0] q[$];
  logic ovr_m = 1'b0;
  logic v_n2, v_n3;

  always @(posedge clk) if (frame_abort) n_abort <= n_abort + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_data = b;
    serial_clk  = 1'b0;
    repeat (6) @(negedge clk);
    serial_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // MSB of w goes out first. Around the final sampled rise, rd_valid is
  // recorded just before (v_n2) and just after (v_n3) the push edge.
  task automatic send_word(input logic [9:0] w, input logic pop_at_push);
    for (int i = 9; i >= 1; i--) send_bit(w[i]);
    @(negedge clk);
    serial_data = w[0];
    serial_clk  = 1'b0;
    repeat (6) @(negedge clk);
    serial_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v_n2 = rd_valid;
    if (pop_at_push) rd_ready = 1'b1;
    @(negedge clk);
    v_n3 = rd_valid;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic model_push(input logic [9:0] w);
    if (q.size() < 4) q.push_back(w);
    else ovr_m = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    e = (q.size() > 0) ? q[0] : 10'h000;
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, q.size() > 0});
    chk({tag, "_data"}, {22'd0, rd_data}, {22'd0, e});
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    chk({tag, "_level"}, {29'd0, level}, q.size());
  endtask

  initial begin
    logic [9:0] w;
    int a0;
    int npop;

    @(negedge clk);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", {22'd0, rd_data}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_abort", {31'd0, frame_abort}, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Basic MSB-first word and push latency
    send_word(10'b1011001110, 1'b0);
    model_push(10'b1011001110);
    chk("lat_before_push", {31'd0, v_n2}, 0);
    chk("lat_after_push", {31'd0, v_n3}, 1);
    chk("t1_data", {22'd0, rd_data}, 32'h2CE);
    chk("t1_level", {29'd0, level}, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    void'(q.pop_front());
    chk("t1_pop_valid", {31'd0, rd_valid}, 0);
    chk("t1_pop_data", {22'd0, rd_data}, 0);

    // LSB-first instance: first bit lands in bit 0
    send_word(10'b1000000000, 1'b0);
    model_push(10'b1000000000);
    chk("lsb_head0", {22'd0, lsb_data}, 32'h1CD);
    rd_ready_l = 1'b1;
    @(negedge clk);
    rd_ready_l = 1'b0;
    chk("lsb_word", {22'd0, lsb_data}, 32'h001);
    pop_check("t2_main");

    // Fill, overflow, drain, clear
    for (int k = 1; k <= 5; k++) begin
      send_word(10'(k), 1'b0);
      model_push(10'(k));
      if (k == 4) chk("t3_full_level", {29'd0, level}, 4);
    end
    chk("t3_level_after5", {29'd0, level}, 4);
    chk("t3_overrun", {31'd0, overrun}, {31'd0, ovr_m});
    for (int k = 0; k < 4; k++) pop_check("t3_drain");
    chk("t3_overrun_held", {31'd0, overrun}, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    ovr_m = 1'b0;
    chk("t3_overrun_clr", {31'd0, overrun}, 0);

    // Full FIFO with pop coinciding with the push
    for (int k = 0; k < 4; k++) begin
      send_word(10'(16 + k), 1'b0);
      model_push(10'(16 + k));
    end
    send_word(10'h066, 1'b1);
    void'(q.pop_front());
    q.push_back(10'h066);
    chk("t4_level", {29'd0, level}, 4);
    chk("t4_overrun", {31'd0, overrun}, 0);
    for (int k = 0; k < 4; k++) pop_check("t4_drain");

    // Partial word timeout
    a0 = n_abort;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (240) @(negedge clk);
    chk("to_not_early", n_abort, a0);
    repeat (60) @(negedge clk);
    chk("to_one_pulse", n_abort, a0 + 1);
    chk("to_no_push", {29'd0, level}, 0);
    send_word(10'h3A5, 1'b0);
    model_push(10'h3A5);
    pop_check("to_next_word");

    // Randomised words with random drains between them
    for (int n = 0; n < 12; n++) begin
      w = 10'($urandom);
      send_word(w, 1'b0);
      model_push(w);
      chk("rnd_level", {29'd0, level}, q.size());
      chk("rnd_overrun", {31'd0, overrun}, {31'd0, ovr_m});
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) if (q.size() > 0) pop_check("rnd_pop");
    end
    while (q.size() > 0) pop_check("rnd_drain");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    ovr_m = 1'b0;

    // Enable dropped mid-word, re-raised with serial_clk high
    a0 = n_abort;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    send_word(10'h155, 1'b0);
    model_push(10'h155);
    chk("en_level", {29'd0, level}, 1);
    pop_check("en_word");
    chk("en_no_abort", n_abort, a0);

    // Asynchronous reset with data held
    send_word(10'h011, 1'b0);
    send_word(10'h022, 1'b0);
    chk("rst2_level_before", {29'd0, level}, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_level", {29'd0, level}, 0);
    chk("rst2_valid", {31'd0, rd_valid}, 0);
    chk("rst2_data", {22'd0, rd_data}, 0);
    q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
